// File: rtl/host_cmd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// host_cmd_pkg : frame opcodes, command-type and state encodings for host_cmd_master
// Rev 1.0
// -----------------------------------------------------------------------------
package host_cmd_pkg;

    localparam logic [7:0] OPC_RF_WR   = 8'hAA;
    localparam logic [7:0] OPC_RF_RD   = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'd0,
        CMD_RF_RD   = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    function automatic logic [7:0] opcode(cmd_type_e t);
        case (t)
            CMD_RF_WR:  opcode = OPC_RF_WR;
            CMD_RF_RD:  opcode = OPC_RF_RD;
            CMD_ALU_OP: opcode = OPC_ALU_OP;
            default:    opcode = OPC_ALU_NOP;
        endcase
    endfunction

    function automatic logic [2:0] frame_len(cmd_type_e t);
        case (t)
            CMD_RF_WR:  frame_len = 3'd3;
            CMD_RF_RD:  frame_len = 3'd2;
            CMD_ALU_OP: frame_len = 3'd4;
            default:    frame_len = 3'd2;
        endcase
    endfunction

    function automatic logic [1:0] rsp_len(cmd_type_e t);
        case (t)
            CMD_RF_WR: rsp_len = 2'd0;
            CMD_RF_RD: rsp_len = 2'd1;
            default:   rsp_len = 2'd2;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/host_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// host_cmd_master : serialises host commands into UART frames and collects replies
// Rev 1.0
// -----------------------------------------------------------------------------
module host_cmd_master
    import host_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CMD_VLD,
    output logic                    CMD_RDY,
    input  logic [1:0]              CMD_TYPE,
    input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]   CMD_DATA,
    input  logic [DATA_WIDTH-1:0]   CMD_OPB,
    input  logic [3:0]              CMD_FUN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    input  logic                    TX_BUSY,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic [2*DATA_WIDTH-1:0] RSP_DATA,
    output logic                    RSP_VLD,
    output logic                    RSP_ERR,
    output logic                    BUSY
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
    // Fires on the last WAIT_RSP cycle so DONE lands TIMEOUT_CYCLES after the last event.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

    state_e                  state_q, state_d;
    cmd_type_e               type_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q, opb_q;
    logic [3:0]              fun_q;
    logic [2:0]              idx_q;
    logic [1:0]              rx_idx_q;
    logic [TO_W-1:0]         to_cnt_q;
    logic [2*DATA_WIDTH-1:0] rsp_data_q;
    logic                    err_q;

    logic                    accept, tx_acc, last_tx, rx_ok, rx_last, timeout;
    logic [DATA_WIDTH-1:0]   tx_byte;

    assign accept  = (state_q == ST_IDLE) && CMD_VLD;
    assign tx_acc  = (state_q == ST_SEND) && !TX_BUSY;
    assign last_tx = tx_acc && (idx_q == frame_len(type_q) - 3'd1);
    assign rx_ok   = (state_q == ST_WAIT_RSP) && RX_D_VLD;
    assign rx_last = rx_ok && (rx_idx_q == rsp_len(type_q) - 2'd1);
    assign timeout = (state_q == ST_WAIT_RSP) && !RX_D_VLD && (to_cnt_q == TO_LAST);
    assign RSP_DATA = rsp_data_q;

    always_comb begin
        case (idx_q)
            3'd0:    tx_byte = DATA_WIDTH'(opcode(type_q));
            3'd1:    tx_byte = (type_q == CMD_ALU_OP)  ? data_q :
                               (type_q == CMD_ALU_NOP) ? DATA_WIDTH'(fun_q) : DATA_WIDTH'(addr_q);
            3'd2:    tx_byte = (type_q == CMD_ALU_OP)  ? opb_q : data_q;
            default: tx_byte = DATA_WIDTH'(fun_q);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        CMD_RDY   = 1'b0;
        TX_D_VLD  = 1'b0;
        TX_P_DATA = '0;
        RSP_VLD   = 1'b0;
        RSP_ERR   = 1'b0;
        BUSY      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                CMD_RDY = 1'b1;
                BUSY    = 1'b0;
                if (CMD_VLD) state_d = ST_SEND;
            end
            ST_SEND: begin
                TX_D_VLD  = 1'b1;
                TX_P_DATA = tx_byte;
                if (last_tx) state_d = (type_q == CMD_RF_WR) ? ST_DONE : ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (rx_last || timeout) state_d = ST_DONE;
            end
            default: begin
                RSP_VLD = 1'b1;
                RSP_ERR = err_q;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            type_q     <= CMD_RF_WR;
            addr_q     <= '0;
            data_q     <= '0;
            opb_q      <= '0;
            fun_q      <= '0;
            idx_q      <= '0;
            rx_idx_q   <= '0;
            to_cnt_q   <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                type_q     <= cmd_type_e'(CMD_TYPE);
                addr_q     <= CMD_ADDR;
                data_q     <= CMD_DATA;
                opb_q      <= CMD_OPB;
                fun_q      <= CMD_FUN;
                idx_q      <= '0;
                rx_idx_q   <= '0;
                rsp_data_q <= '0;
                err_q      <= 1'b0;
            end else if (tx_acc) begin
                idx_q <= idx_q + 3'd1;
            end
            if (rx_ok) begin
                rx_idx_q <= rx_idx_q + 2'd1;
                if (rx_idx_q == 2'd0) rsp_data_q[DATA_WIDTH-1:0] <= RX_P_DATA;
                else                  rsp_data_q[2*DATA_WIDTH-1:DATA_WIDTH] <= RX_P_DATA;
            end
            if (timeout) err_q <= 1'b1;
            // Idle outside WAIT_RSP; every received byte restarts the wait.
            if ((state_q != ST_WAIT_RSP) || RX_D_VLD) to_cnt_q <= '0;
            else                                      to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_host_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// tb_host_cmd_master : directed scoreboard bench for host_cmd_master
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_host_cmd_master;

    localparam int TO = 64;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CMD_VLD = 1'b0;
    logic        CMD_RDY;
    logic [1:0]  CMD_TYPE = '0;
    logic [3:0]  CMD_ADDR = '0;
    logic [7:0]  CMD_DATA = '0;
    logic [7:0]  CMD_OPB  = '0;
    logic [3:0]  CMD_FUN  = '0;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_BUSY = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [15:0] RSP_DATA;
    logic        RSP_VLD;
    logic        RSP_ERR;
    logic        BUSY;

    host_cmd_master #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_TYPE(CMD_TYPE),
        .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_OPB(CMD_OPB), .CMD_FUN(CMD_FUN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RSP_DATA(RSP_DATA), .RSP_VLD(RSP_VLD), .RSP_ERR(RSP_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int          total_cnt = 0;
    int          pass_cnt  = 0;
    logic [7:0]  exp_tx[$];
    logic [16:0] exp_rsp[$];   // {err, data}
    int unsigned last_acc_cyc = 0, last_rx_cyc = 0, rsp_cyc = 0;
    int          rsp_cnt = 0, stall_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Scoreboard side: pops expected TX bytes / responses as the DUT produces them.
    always @(negedge CLK) begin
        if (!RST) begin
            prev_stall = 1'b0;
        end else begin
            if (BUSY && exp_tx.size() != 0) chk("tx_gap", TX_D_VLD, 1);
            if (prev_stall) begin
                chk("tx_hold_vld", TX_D_VLD, 1);
                chk("tx_hold_data", TX_P_DATA, prev_data);
            end
            if (TX_D_VLD && TX_BUSY) stall_cnt++;
            prev_stall = TX_D_VLD && TX_BUSY;
            prev_data  = TX_P_DATA;
            if (TX_D_VLD && !TX_BUSY) begin
                if (exp_tx.size() == 0) chk("tx_extra", exp_tx.size(), 1);
                else chk("tx_byte", TX_P_DATA, exp_tx.pop_front());
                last_acc_cyc = cyc;
            end
            if (RX_D_VLD) last_rx_cyc = cyc;
            if (RSP_VLD) begin
                if (exp_rsp.size() == 0) chk("rsp_extra", exp_rsp.size(), 1);
                else chk("rsp", {RSP_ERR, RSP_DATA}, exp_rsp.pop_front());
                rsp_cyc = cyc;
                rsp_cnt++;
            end
        end
    end

    task automatic send_cmd(input logic [1:0] t, input logic [3:0] a,
                            input logic [7:0] d, input logic [7:0] b, input logic [3:0] f);
        for (int g = 0; g < 50 && !CMD_RDY; g++) begin @(posedge CLK); #1; end
        chk("cmd_rdy", CMD_RDY, 1);
        CMD_TYPE = t; CMD_ADDR = a; CMD_DATA = d; CMD_OPB = b; CMD_FUN = f; CMD_VLD = 1'b1;
        @(posedge CLK); #1;
        CMD_VLD  = 1'b0;
        CMD_TYPE = 2'($urandom); CMD_ADDR = 4'($urandom);
        CMD_DATA = 8'($urandom); CMD_OPB  = 8'($urandom); CMD_FUN = 4'($urandom);
        chk("tx_rise", TX_D_VLD, 1);
        chk("busy_hi", BUSY, 1);
        chk("cmd_rdy_lo", CMD_RDY, 0);
    endtask

    task automatic drain(input int n);
        for (int g = 0; g < 200 && exp_tx.size() > n; g++) begin @(negedge CLK); #1; end
        chk("tx_drain", exp_tx.size(), n);
    endtask

    task automatic rx_at(input int unsigned tgt, input logic [7:0] v);
        for (int g = 0; g < 10000 && cyc < tgt; g++) begin @(posedge CLK); #1; end
        RX_P_DATA = v; RX_D_VLD = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int n0 = rsp_cnt;
        for (int g = 0; g < budget && rsp_cnt == n0; g++) begin @(negedge CLK); #1; end
        chk({tag, "_done"}, rsp_cnt - n0, 1);
        @(posedge CLK); #1;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_cmd_rdy", CMD_RDY, 1);
        chk("rst_tx_vld", TX_D_VLD, 0);
        chk("rst_tx_data", TX_P_DATA, 0);
        chk("rst_rsp", {RSP_VLD, RSP_ERR, RSP_DATA}, 0);
        chk("rst_busy", BUSY, 0);
        RST = 1'b1;
        @(posedge CLK); #1;

        // RF_WR addr=3 data=0x5A, stray RX during SEND must be ignored
        exp_tx.push_back(8'hAA); exp_tx.push_back(8'h03); exp_tx.push_back(8'h5A);
        exp_rsp.push_back(17'h0_0000);
        send_cmd(2'd0, 4'd3, 8'h5A, 8'h00, 4'd0);
        RX_P_DATA = 8'hEE; RX_D_VLD = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD = 1'b0;
        drain(0);
        wait_rsp("wr", 10);
        chk("wr_lat", rsp_cyc - last_acc_cyc, 1);

        // RF_RD addr=2, reply 0x81
        exp_tx.push_back(8'hBB); exp_tx.push_back(8'h02);
        exp_rsp.push_back(17'h0_0081);
        send_cmd(2'd1, 4'd2, 8'h00, 8'h00, 4'd0);
        drain(0);
        rx_at(last_acc_cyc + 3, 8'h81);
        wait_rsp("rd", 10);
        chk("rd_lat", rsp_cyc - last_rx_cyc, 1);

        // ALU_OP A=0x10 B=0x20 fun=0, replies 0x30, 0x00
        exp_tx.push_back(8'hCC); exp_tx.push_back(8'h10);
        exp_tx.push_back(8'h20); exp_tx.push_back(8'h00);
        exp_rsp.push_back(17'h0_0030);
        send_cmd(2'd2, 4'd0, 8'h10, 8'h20, 4'd0);
        drain(0);
        rx_at(last_acc_cyc + 2, 8'h30);
        rx_at(last_rx_cyc + 3, 8'h00);
        wait_rsp("alu", 10);

        // ALU_NOP fun=0xF with the transmitter stalled 5 cycles on byte 2
        exp_tx.push_back(8'hDD); exp_tx.push_back(8'h0F);
        exp_rsp.push_back(17'h0_0201);
        send_cmd(2'd3, 4'd0, 8'h00, 8'h00, 4'hF);
        drain(1);
        stall_cnt = 0;
        @(posedge CLK); #1;
        TX_BUSY = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        TX_BUSY = 1'b0;
        drain(0);
        chk("nop_stall_cycles", stall_cnt, 5);
        rx_at(last_acc_cyc + 2, 8'h01);
        rx_at(last_rx_cyc + 2, 8'h02);
        wait_rsp("nop", 10);

        // RF_RD with no reply: timeout exactly TO cycles after last accept
        exp_tx.push_back(8'hBB); exp_tx.push_back(8'h07);
        exp_rsp.push_back(17'h1_0000);
        send_cmd(2'd1, 4'd7, 8'h00, 8'h00, 4'd0);
        drain(0);
        wait_rsp("to", TO + 20);
        chk("to_lat", rsp_cyc - last_acc_cyc, TO);

        // Next command after a timeout completes normally
        exp_tx.push_back(8'hAA); exp_tx.push_back(8'h01); exp_tx.push_back(8'h33);
        exp_rsp.push_back(17'h0_0000);
        send_cmd(2'd0, 4'd1, 8'h33, 8'h00, 4'd0);
        drain(0);
        wait_rsp("wr2", 10);

        // Second byte lands on the would-be timeout cycle: counted, no error
        exp_tx.push_back(8'hDD); exp_tx.push_back(8'h03);
        exp_rsp.push_back(17'h0_2211);
        send_cmd(2'd3, 4'd0, 8'h00, 8'h00, 4'd3);
        drain(0);
        rx_at(last_acc_cyc + 10, 8'h11);
        rx_at(last_rx_cyc + TO - 1, 8'h22);
        wait_rsp("edge", 10);
        chk("edge_lat", rsp_cyc - last_rx_cyc, 1);

        // Partial reply then timeout: error with the first byte retained
        exp_tx.push_back(8'hCC); exp_tx.push_back(8'h01);
        exp_tx.push_back(8'h02); exp_tx.push_back(8'h04);
        exp_rsp.push_back(17'h1_0044);
        send_cmd(2'd2, 4'd0, 8'h01, 8'h02, 4'd4);
        drain(0);
        rx_at(last_acc_cyc + 2, 8'h44);
        wait_rsp("part", TO + 20);
        chk("part_lat", rsp_cyc - last_rx_cyc, TO);

        // Reset while byte 3 of an ALU_OP is on the wire
        exp_tx.push_back(8'hCC); exp_tx.push_back(8'h55);
        exp_tx.push_back(8'h66); exp_tx.push_back(8'h07);
        send_cmd(2'd2, 4'd0, 8'h55, 8'h66, 4'd7);
        drain(2);
        @(posedge CLK); #2;
        RST = 1'b0;
        #1;
        chk("mid_rst_tx_vld", TX_D_VLD, 0);
        chk("mid_rst_tx_data", TX_P_DATA, 0);
        chk("mid_rst_cmd_rdy", CMD_RDY, 1);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_rsp", {RSP_VLD, RSP_ERR, RSP_DATA}, 0);
        exp_tx.delete();
        exp_rsp.delete();
        @(posedge CLK); #1;
        RST = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        chk("post_rst_idle", {BUSY, TX_D_VLD, CMD_RDY}, 3'b001);
        exp_tx.push_back(8'hAA); exp_tx.push_back(8'h03); exp_tx.push_back(8'h5A);
        exp_rsp.push_back(17'h0_0000);
        send_cmd(2'd0, 4'd3, 8'h5A, 8'h00, 4'd0);
        drain(0);
        wait_rsp("wr3", 10);
        chk("wr3_lat", rsp_cyc - last_acc_cyc, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/host_cmd_master.md
HOST_CMD_MASTER -- requirements
Module: host_cmd_master

Interface
REQ-001 Parameter DATA_WIDTH, 8, width of a UART frame byte and of register data.
REQ-002 Parameter ADDR_WIDTH, 4, register file address width.
REQ-003 Parameter TIMEOUT_CYCLES, 4096, maximum number of CLK cycles to wait for a response byte.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset. The ports are CLK and RST.
REQ-005 CLK  in  1  system clock; every flop is rising-edge.
REQ-006 RST  in  1  asynchronous active-low reset.
REQ-007 CMD_VLD  in  1  a command request is present.
REQ-008 CMD_RDY  out  1  the block accepts a command; high only in IDLE.
REQ-009 CMD_TYPE  in  2  command type: 0 = RF_WR, 1 = RF_RD, 2 = ALU_OP, 3 = ALU_NOP.
REQ-010 CMD_ADDR  in  ADDR_WIDTH  register address, zero-extended into its frame byte.
REQ-011 CMD_DATA  in  DATA_WIDTH  write data (RF_WR) or operand A (ALU_OP).
REQ-012 CMD_OPB  in  DATA_WIDTH  operand B (ALU_OP).
REQ-013 CMD_FUN  in  4  ALU function, zero-extended into its frame byte.
REQ-014 TX_P_DATA  out  DATA_WIDTH  frame byte to the UART transmitter.
REQ-015 TX_D_VLD  out  1  TX_P_DATA is valid.
REQ-016 TX_BUSY  in  1  the transmitter cannot accept a byte.
REQ-017 RX_P_DATA  in  DATA_WIDTH  response byte from the UART receiver.
REQ-018 RX_D_VLD  in  1  one-cycle strobe marking a valid RX_P_DATA.
REQ-019 RSP_DATA  out  2*DATA_WIDTH  assembled response.
REQ-020 RSP_VLD  out  1  one-cycle completion strobe.
REQ-021 RSP_ERR  out  1  qualifies RSP_VLD; high means a timeout occurred.
REQ-022 BUSY  out  1  high whenever the block is not in IDLE.

Function
REQ-023 The frames SHALL be exactly as listed:
- RF_WR: 0xAA, addr, data. No response bytes are expected.
- RF_RD: 0xBB, addr. One response byte is expected.
- ALU_OP: 0xCC, A, B, fun. Two response bytes are expected.
- ALU_NOP: 0xDD, fun. Two response bytes are expected.
REQ-024 The state machine SHALL have four states, IDLE, SEND, WAIT_RSP and DONE, with these transitions:
- IDLE to SEND on CMD_VLD && CMD_RDY.
- SEND to WAIT_RSP after the last byte is accepted, or SEND to DONE for RF_WR.
- WAIT_RSP to DONE on the final response byte or on timeout.
- DONE to IDLE after one cycle.
REQ-025 All command fields SHALL be captured on the accept cycle. Later changes to the inputs SHALL have no effect.
REQ-026 TX_D_VLD SHALL rise in the cycle after accept. A byte is accepted on a cycle with TX_D_VLD=1 and TX_BUSY=0.
REQ-027 TX_D_VLD and TX_P_DATA SHALL be held stable until the byte is accepted. The next byte SHALL be presented in the following cycle.
REQ-028 A byte index counter SHALL sequence the frame bytes and SHALL clear on entry to SEND.
REQ-029 Response bytes SHALL be placed as follows:
- RF_RD: the byte goes to RSP_DATA[7:0], and RSP_DATA[15:8] is 0.
- ALU: the first byte goes to [7:0] and the second to [15:8] (LSB first).
REQ-030 RSP_VLD SHALL pulse in DONE, one cycle after the final RX_D_VLD or the final TX accept. RSP_DATA SHALL hold its value until the next accept.
REQ-031 RF_WR SHALL complete with RSP_DATA=0 and RSP_ERR=0.
REQ-032 The timeout counter SHALL run only in WAIT_RSP and SHALL clear on entry and on each RX_D_VLD. Reaching TIMEOUT_CYCLES-1 SHALL go to DONE with RSP_ERR=1 and the partial data retained.
REQ-033 RX_D_VLD SHALL be ignored in IDLE, SEND and DONE. An RX_D_VLD arriving on the timeout cycle SHALL be counted as a byte, and the timeout SHALL NOT fire.
REQ-034 CMD_RDY SHALL be low from accept through DONE, so a new command can be accepted in the cycle after DONE at the earliest.

Reset
REQ-035 Asserting RST SHALL, at any time including mid-frame, immediately force:
- state = IDLE;
- TX_D_VLD, RSP_VLD, RSP_ERR and BUSY = 0;
- CMD_RDY = 1;
- TX_P_DATA, RSP_DATA and all counters = 0.
REQ-036 An aborted frame SHALL NOT be resumed after reset.

Structure
REQ-037 The shared package host_cmd_pkg SHALL hold:
- the opcode constants 0xAA, 0xBB, 0xCC and 0xDD;
- the CMD_TYPE encodings;
- the state encoding.
REQ-038 The design SHALL be a single module with no sub-module. The timeout counter and the byte index counter are inline.

Verification
REQ-039 RF_WR addr=3 data=0x5A with TX_BUSY=0: TX bytes are 0xAA, 0x03, 0x5A on consecutive cycles, then RSP_VLD=1, RSP_ERR=0, RSP_DATA=0x0000.
REQ-040 RF_RD addr=2, with RX 0x81 sent after the frame: TX bytes are 0xBB, 0x02, and RSP_DATA=0x0081 follows one cycle after the RX strobe.
REQ-041 ALU_OP A=0x10 B=0x20 fun=0, with RX 0x30 then 0x00: TX bytes are 0xCC, 0x10, 0x20, 0x00, and RSP_DATA=0x0030.
REQ-042 ALU_NOP with TX_BUSY held high for 5 cycles on the second byte: 0x0F is held stable for those 5 cycles, no byte is dropped or duplicated, and RX 0x01, 0x02 gives RSP_DATA=0x0201.
REQ-043 RF_RD with no RX: RSP_VLD and RSP_ERR pulse exactly TIMEOUT_CYCLES cycles after the last TX accept. A second command is then accepted normally.
REQ-044 RST asserted during byte 3 of an ALU_OP: the outputs are at their reset values immediately, and a subsequent RF_WR frame is correct.
